// File: rtl/serial_loader_pkg.sv
// Shared constants and state encoding for the serial program loader.
// Imported by the loader FSM and its timeout counter.
package serial_loader_pkg;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam logic [7:0] ACK_BYTE     = 8'h06;
  localparam logic [7:0] NAK_BYTE     = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_RESP
  } state_e;

  // States in which a frame is being received and the idle-gap timer runs.
  function automatic logic in_frame(input state_e s);
    return (s != ST_IDLE) && (s != ST_RESP);
  endfunction

endpackage

// File: rtl/serial_loader_timeout.sv
// Inter-byte idle timer: reloads on clear or while inactive, counts down while
// active, and flags expiry after TIMEOUT_CYCLES cycles without a clear.
module serial_loader_timeout
  import serial_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic clear,
  output logic expire
);

  localparam int unsigned      CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave it unassigned and infer a latch.
    cnt_d = cnt_q;
    if (clear || !active) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // A strobe in the expiring cycle wins over the timeout.
  assign expire = active && !clear && (cnt_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) cnt_q <= LOAD_VAL;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/serial_loader.sv
// Serial frame decoder: writes SYNC/ADDR/LEN/DATA/CSUM packets into cpu1
// instruction memory while holding the CPU, then answers ACK or NAK.
module serial_loader
  import serial_loader_pkg::*;
#(
  parameter int unsigned ADDR_W         = 10,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              new_rx_data,
  output logic [7:0]        tx_data,
  output logic              new_tx_data,
  input  logic              tx_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              cpu_hold,
  output logic              load_ok
);

  state_e            state_q, state_d;
  logic [7:0]        addr_hi_q, addr_hi_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [7:0]        left_q, left_d;
  logic [7:0]        csum_q, csum_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              new_tx_q, new_tx_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              load_ok_q, load_ok_d;
  logic              timer_expire;

  serial_loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .active(in_frame(state_q)),
    .clear (new_rx_data),
    .expire(timer_expire)
  );

  always_comb begin
    state_d     = state_q;
    addr_hi_d   = addr_hi_q;
    wr_ptr_d    = wr_ptr_q;
    left_d      = left_q;
    csum_d      = csum_q;
    tx_data_d   = tx_data_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    new_tx_d    = 1'b0;
    load_ok_d   = 1'b0;

    if (in_frame(state_q) && new_rx_data) csum_d = csum_q + rx_data;

    case (state_q)
      ST_IDLE: begin
        if (new_rx_data && (rx_data == SYNC_BYTE)) begin
          csum_d  = '0;
          state_d = ST_ADDR_HI;
        end
      end
      ST_ADDR_HI: begin
        if (new_rx_data) begin
          addr_hi_d = rx_data;
          state_d   = ST_ADDR_LO;
        end
      end
      ST_ADDR_LO: begin
        if (new_rx_data) begin
          wr_ptr_d = ADDR_W'({addr_hi_q, rx_data});
          state_d  = ST_LEN;
        end
      end
      ST_LEN: begin
        // LEN of 0 counts down through 255 and so covers 256 bytes.
        if (new_rx_data) begin
          left_d  = rx_data;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (new_rx_data) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = wr_ptr_q;
          mem_wdata_d = rx_data;
          wr_ptr_d    = wr_ptr_q + ADDR_W'(1);
          left_d      = left_q - 8'd1;
          if (left_q == 8'd1) state_d = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (new_rx_data) begin
          tx_data_d = (csum_d == 8'h00) ? ACK_BYTE : NAK_BYTE;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        // Stay here for the strobe cycle so cpu_hold covers it.
        if (new_tx_q) begin
          state_d = ST_IDLE;
        end else if (!tx_busy) begin
          new_tx_d  = 1'b1;
          load_ok_d = (tx_data_q == ACK_BYTE);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (timer_expire) state_d = ST_IDLE;

    cpu_hold_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_hi_q   <= '0;
      wr_ptr_q    <= '0;
      left_q      <= '0;
      csum_q      <= '0;
      tx_data_q   <= '0;
      new_tx_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      cpu_hold_q  <= 1'b0;
      load_ok_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_hi_q   <= addr_hi_d;
      wr_ptr_q    <= wr_ptr_d;
      left_q      <= left_d;
      csum_q      <= csum_d;
      tx_data_q   <= tx_data_d;
      new_tx_q    <= new_tx_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      cpu_hold_q  <= cpu_hold_d;
      load_ok_q   <= load_ok_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign new_tx_data = new_tx_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_we      = mem_we_q;
  assign cpu_hold    = cpu_hold_q;
  assign load_ok     = load_ok_q;

endmodule

// File: tb/tb_serial_loader.sv
// Scoreboard bench for serial_loader: expected writes and responses are queued
// as frames are sent and compared when the DUT produces them.
module tb_serial_loader;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned TO_CYC = 100;
  localparam logic [7:0]  SYNC   = 8'hA5;
  localparam logic [7:0]  ACK    = 8'h06;
  localparam logic [7:0]  NAK    = 8'h15;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [7:0]        rx_data;
  logic              new_rx_data;
  logic [7:0]        tx_data;
  logic              new_tx_data;
  logic              tx_busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic              cpu_hold;
  logic              load_ok;

  always #10 clk = ~clk;

  serial_loader #(
    .ADDR_W        (ADDR_W),
    .SYNC_BYTE     (SYNC),
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .new_rx_data(new_rx_data),
    .tx_data    (tx_data),
    .new_tx_data(new_tx_data),
    .tx_busy    (tx_busy),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .cpu_hold   (cpu_hold),
    .load_ok    (load_ok)
  );

  int         check_cnt   = 0;
  int         pass_cnt    = 0;
  int         tx_cnt      = 0;
  int         lok_cnt     = 0;
  int         exp_ack_cnt = 0;
  logic       prev_tx     = 1'b0;
  wr_t        exp_wr_q[$];
  logic [7:0] exp_tx_q[$];
  logic [7:0] payload_q[$];
  wr_t        mon_wr;
  logic [7:0] mon_tx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Monitor: retire writes and responses against the scoreboard.
  always @(negedge clk) begin
    if (mem_we) begin
      if (exp_wr_q.size() == 0) begin
        check("unexpected_we", 32'(mem_we), 32'd0);
      end else begin
        mon_wr = exp_wr_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(mon_wr.addr));
        check("wr_data", 32'(mem_wdata), 32'(mon_wr.data));
      end
    end
    if (new_tx_data) begin
      tx_cnt++;
      check("tx_while_busy", 32'(tx_busy), 32'd0);
      check("tx_back_to_back", 32'(prev_tx), 32'd0);
      check("hold_at_tx", 32'(cpu_hold), 32'd1);
      if (exp_tx_q.size() == 0) begin
        check("unexpected_tx", 32'(new_tx_data), 32'd0);
      end else begin
        mon_tx = exp_tx_q.pop_front();
        check("tx_data", 32'(tx_data), 32'(mon_tx));
        check("load_ok_at_tx", 32'(load_ok), 32'(mon_tx == ACK));
      end
    end else if (load_ok) begin
      check("load_ok_without_tx", 32'(load_ok), 32'd0);
    end
    if (load_ok) lok_cnt++;
    prev_tx = new_tx_data;
  end

  task automatic send_byte(input logic [7:0] b, input bit exp_hold, input bit is_data, input int gap);
    repeat (gap) @(posedge clk);
    @(posedge clk); #1;
    rx_data     = b;
    new_rx_data = 1'b1;
    @(negedge clk);
    check("hold_at_rx", 32'(cpu_hold), 32'(exp_hold));
    @(posedge clk); #1;
    new_rx_data = 1'b0;
    if (is_data) begin
      @(negedge clk);
      check("we_latency", 32'(mem_we), 32'd1);
    end
  endtask

  // Sends SYNC, header, payload_q and a checksum computed here; corrupt bumps it.
  task automatic send_frame(input logic [7:0] hi, input logic [7:0] lo, input bit corrupt, input int gap);
    logic [7:0]        len;
    logic [7:0]        sum;
    logic [7:0]        csum;
    logic [ADDR_W-1:0] a;
    wr_t               w;
    len = 8'(payload_q.size());
    a   = ADDR_W'({hi, lo});
    sum = hi + lo + len;
    send_byte(SYNC, 1'b0, 1'b0, gap);
    send_byte(hi, 1'b1, 1'b0, gap);
    send_byte(lo, 1'b1, 1'b0, gap);
    send_byte(len, 1'b1, 1'b0, gap);
    foreach (payload_q[i]) begin
      w.addr = a;
      w.data = payload_q[i];
      exp_wr_q.push_back(w);
      sum = sum + payload_q[i];
      a   = a + ADDR_W'(1);
      send_byte(payload_q[i], 1'b1, 1'b1, gap);
    end
    csum = 8'h00 - sum;
    if (corrupt) csum = csum + 8'd1;
    if (8'(sum + csum) == 8'h00) begin
      exp_tx_q.push_back(ACK);
      exp_ack_cnt++;
    end else begin
      exp_tx_q.push_back(NAK);
    end
    send_byte(csum, 1'b1, 1'b0, gap);
  endtask

  task automatic wait_tx(input string tag, input int budget);
    int start;
    int n;
    start = tx_cnt;
    n     = 0;
    while (tx_cnt == start && n < budget) begin
      @(posedge clk);
      n++;
    end
    check(tag, 32'(tx_cnt - start), 32'd1);
    @(negedge clk);
    check({tag, "_hold_drop"}, 32'(cpu_hold), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    check({tag, "_new_tx"}, 32'(new_tx_data), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_load_ok"}, 32'(load_ok), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tx_before;
    rx_data     = 8'h00;
    new_rx_data = 1'b0;
    tx_busy     = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_outputs_zero("reset");

    // Good frame: three bytes at 0x010, ACK.
    payload_q = '{8'h11, 8'h22, 8'h33};
    send_frame(8'h00, 8'h10, 1'b0, 0);
    wait_tx("ack_frame", 50);
    check("load_ok_count_ack", 32'(lok_cnt), 32'd1);

    // Same frame with a bad checksum: writes still land, NAK, no load_ok.
    send_frame(8'h00, 8'h10, 1'b1, 2);
    wait_tx("nak_frame", 50);
    check("load_ok_count_nak", 32'(lok_cnt), 32'd1);

    // Address wrap from 0x3FF to 0x000.
    payload_q = '{8'hAA, 8'hBB};
    send_frame(8'h03, 8'hFF, 1'b0, 1);
    wait_tx("wrap_frame", 50);

    // LEN = 0 carries 256 bytes; the upper address bits are discarded.
    payload_q.delete();
    for (int i = 0; i < 256; i++) payload_q.push_back(8'(i * 7 + 3));
    send_frame(8'h07, 8'hF0, 1'b0, 0);
    wait_tx("len256_frame", 50);
    check("wr_queue_drained_1", 32'(exp_wr_q.size()), 32'd0);

    // Timeout: SYNC, ADDR_HI, then silence.
    tx_before = tx_cnt;
    send_byte(SYNC, 1'b0, 1'b0, 0);
    send_byte(8'h00, 1'b1, 1'b0, 0);
    repeat (TO_CYC - 1) @(posedge clk);
    @(negedge clk);
    check("hold_before_timeout", 32'(cpu_hold), 32'd1);
    @(negedge clk);
    check("hold_after_timeout", 32'(cpu_hold), 32'd0);
    repeat (5) @(posedge clk);
    check("no_tx_on_timeout", 32'(tx_cnt - tx_before), 32'd0);
    payload_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(8'h01, 8'h00, 1'b0, 1);
    wait_tx("after_timeout_frame", 50);

    // Response held off by tx_busy; a byte arriving meanwhile is dropped.
    tx_busy   = 1'b1;
    payload_q = '{8'h5A, 8'hC3};
    tx_before = tx_cnt;
    send_frame(8'h01, 8'h20, 1'b0, 0);
    repeat (200) @(posedge clk);
    send_byte(SYNC, 1'b1, 1'b0, 0);
    repeat (300) @(posedge clk);
    check("tx_held_off", 32'(tx_cnt - tx_before), 32'd0);
    @(posedge clk); #1;
    tx_busy = 1'b0;
    @(negedge clk);
    check("tx_not_same_cycle", 32'(new_tx_data), 32'd0);
    @(negedge clk);
    check("tx_one_after_busy", 32'(new_tx_data), 32'd1);
    @(negedge clk);
    check("tx_single_pulse", 32'(new_tx_data), 32'd0);
    check("hold_after_busy_resp", 32'(cpu_hold), 32'd0);
    repeat (5) @(posedge clk);
    check("resp_byte_dropped", 32'(cpu_hold), 32'd0);

    // Asynchronous reset in the middle of DATA.
    tx_before = tx_cnt;
    send_byte(SYNC, 1'b0, 1'b0, 0);
    send_byte(8'h00, 1'b1, 1'b0, 0);
    send_byte(8'h20, 1'b1, 1'b0, 0);
    send_byte(8'h05, 1'b1, 1'b0, 0);
    mon_wr.addr = 10'h020;
    mon_wr.data = 8'h77;
    exp_wr_q.push_back(mon_wr);
    send_byte(8'h77, 1'b1, 1'b1, 0);
    send_byte(8'h88, 1'b1, 1'b0, 0);
    check("we_before_rst", 32'(mem_we), 32'd1);
    check("addr_before_rst", 32'(mem_addr), 32'h021);
    #4 rst = 1'b1;
    #1 check_outputs_zero("mid_rst");
    repeat (3) @(posedge clk);
    #5 rst = 1'b0;
    send_byte(8'h42, 1'b0, 1'b0, 0);
    repeat (10) @(posedge clk);
    check("garbage_ignored_hold", 32'(cpu_hold), 32'd0);
    check("no_tx_after_rst", 32'(tx_cnt - tx_before), 32'd0);
    payload_q = '{8'hDE};
    send_frame(8'h02, 8'h00, 1'b0, 0);
    wait_tx("after_rst_frame", 50);

    check("wr_queue_drained_2", 32'(exp_wr_q.size()), 32'd0);
    check("tx_queue_drained", 32'(exp_tx_q.size()), 32'd0);
    check("load_ok_total", 32'(lok_cnt), 32'(exp_ack_cnt));

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
